mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_rr.sv | 46 ++++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM encoding for the two-requester memory arbiter.
package mem_arb_pkg;
   localparam int NUM_REQ = 2;
   localparam int STAT_W  = 16;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;
endpackage

// File: rtl/mem_arb_rr.sv
// Grant selection and round-robin pointer for the two-requester arbiter.
// While locked only the owner may be granted; otherwise a lone requester wins
// and a conflict is resolved by rr_q, which then points at the other index.
import mem_arb_pkg::*;

module mem_arb_rr (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               locked,
   input  logic               owner,
   input  logic               accept,
   output logic               grant_idx,
   output logic               grant_vld
);

   logic rr_q;

   // pick the granted requester for this cycle
   always_comb begin
      grant_idx = rr_q;
      grant_vld = 1'b0;
      if (locked) begin
         grant_idx = owner;
         grant_vld = req_valid[owner];
      end else if (&req_valid) begin
         grant_idx = rr_q;
         grant_vld = 1'b1;
      end else if (req_valid[0]) begin
         grant_idx = 1'b0;
         grant_vld = 1'b1;
      end else if (req_valid[1]) begin
         grant_idx = 1'b1;
         grant_vld = 1'b1;
      end
   end

   // after any accepted beat, favour the other requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_q <= 1'b0;
      else if (accept)
         rr_q <= ~grant_idx;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port-per-direction memory with
// one-cycle registered read latency. Holds the lock FSM, the memory muxing
// and the read response pipeline.
// Optional: define MEM_ARB_STATS_EN to add saturating grant/conflict counters.
//
//  state  | meaning
//  ARB    | round-robin among valid requesters
//  LOCKED | only owner_q may be granted until it sends a beat with lock=0
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_write_en,
   output logic [ADDR_W:0]           mem_raddr,
   output logic [ADDR_W:0]           mem_waddr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]         stat_grant0,
   output logic [STAT_W-1:0]         stat_grant1,
   output logic [STAT_W-1:0]         stat_conflict
`endif
);

   arb_state_e         state_q, state_d;
   logic               owner_q;
   logic               locked;
   logic               grant_idx, grant_vld;
   logic               accept;
   logic               sel_we, sel_lock;
   logic [ADDR_W-1:0]  sel_addr;
   logic [NUM_REQ-1:0] rsp_valid_q;

   mem_arb_rr u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .locked    (locked),
      .owner     (owner_q),
      .accept    (accept),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // ready is gated by rst_n so nothing transfers while reset is held
   assign accept    = grant_vld & rst_n;
   assign req_ready = accept ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

   assign sel_we   = req_we[grant_idx];
   assign sel_lock = req_lock[grant_idx];
   assign sel_addr = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];

   assign mem_write_en = accept & sel_we;
   assign mem_waddr    = {1'b0, sel_addr};
   assign mem_raddr    = {1'b0, sel_addr};
   assign mem_wdata    = grant_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

   // memory data is already registered, so it lines up with rsp_valid_q
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = mem_rdata;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ARB;
      else
         state_q <= state_d;
   end

   // next-state: lock taken and released only by accepted beats
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (accept && sel_lock)  state_d = LOCKED;
         LOCKED:  if (accept && !sel_lock) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // FSM outputs
   always_comb begin
      locked = (state_q == LOCKED);
   end

   // owner captured on the beat that takes the lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         owner_q <= 1'b0;
      else if (!locked && accept && sel_lock)
         owner_q <= grant_idx;
   end

   // one-cycle read response pulse to the requester whose read was accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rsp_valid_q <= '0;
      else
         rsp_valid_q <= (accept && !sel_we) ? req_ready : 2'b00;
   end

`ifdef MEM_ARB_STATS_EN
   // saturating counters of accepted beats per requester and conflict cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grant0   <= '0;
         stat_grant1   <= '0;
         stat_conflict <= '0;
      end else begin
         if (accept && !grant_idx && stat_grant0 != '1)
            stat_grant0 <= stat_grant0 + STAT_W'(1);
         if (accept && grant_idx && stat_grant1 != '1)
            stat_grant1 <= stat_grant1 + STAT_W'(1);
         if ((&req_valid) && stat_conflict != '1)
            stat_conflict <= stat_conflict + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory (registered read).
module tb_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid, req_ready, req_we, req_lock, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
   logic            mem_write_en;
   logic [AW:0]     mem_raddr, mem_waddr;
   logic [DW-1:0]   mem [0:2**(AW+1)-1];
`ifdef MEM_ARB_STATS_EN
   logic [15:0]     stat_grant0, stat_grant1, stat_conflict;
`endif

   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_lock     (req_lock),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .mem_write_en (mem_write_en),
      .mem_raddr    (mem_raddr),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
`ifdef MEM_ARB_STATS_EN
      ,
      .stat_grant0   (stat_grant0),
      .stat_grant1   (stat_grant1),
      .stat_conflict (stat_conflict)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_en) mem[mem_waddr] <= mem_wdata;
      mem_rdata <= mem[mem_raddr];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      req_valid = v;
      req_we    = we;
      req_lock  = lk;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   logic [1:0]    exp_g [4];
   logic [1:0]    exp_r [4];
   logic [DW-1:0] exp_d [4];

   initial begin
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_r = '{2'b00, 2'b01, 2'b10, 2'b01};
      exp_d = '{64'h0, 64'h111, 64'h222, 64'h111};
      for (int i = 0; i < 2**(AW+1); i++) mem[i] = '0;
      mem[1]     = 64'h111;
      mem[2]     = 64'h222;
      mem[10'h3FF] = 64'hABC;

      // reset: ready and write enable held low even with valid writes pending
      drive(2'b11, 2'b11, 2'b00, 10'd7, 10'd8, 64'h1, 64'h2);
      #12;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_we", mem_write_en, 1'b0);
      chk("rst_rsp", rsp_valid, 2'b00);

      // write req0 then read req1 from the same address
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b01, 2'b01, 2'b00, 10'h005, 10'h0, 64'hDEAD, 64'h0);
      #1;
      chk("wr_ready", req_ready, 2'b01);
      chk("wr_en", mem_write_en, 1'b1);
      chk("wr_addr", mem_waddr, 11'h005);
      chk("wr_data", mem_wdata, 64'hDEAD);
      @(negedge clk);
      drive(2'b10, 2'b00, 2'b00, 10'h0, 10'h005, 64'h0, 64'h0);
      #1;
      chk("rd_ready", req_ready, 2'b10);
      chk("rd_no_we", mem_write_en, 1'b0);
      chk("rd_addr", mem_raddr, 11'h005);
      chk("rd_rsp_early", rsp_valid, 2'b00);
      @(negedge clk);
      drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 64'h0, 64'h0);
      #1;
      chk("rd_rsp", rsp_valid, 2'b10);
      chk("rd_data", rsp_rdata, 64'hDEAD);
      @(negedge clk);
      chk("rd_rsp_pulse", rsp_valid, 2'b00);

      // top word address keeps MSB of mem_raddr at 0
      drive(2'b01, 2'b00, 2'b00, 10'h3FF, 10'h0, 64'h0, 64'h0);
      #1;
      chk("top_addr", mem_raddr, 11'h3FF);
      @(negedge clk);
      drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 64'h0, 64'h0);
      #1;
      chk("top_rsp", rsp_valid, 2'b01);
      chk("top_data", rsp_rdata, 64'hABC);

      // both requesters reading continuously after reset alternate 0,1,0,1
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b11, 2'b00, 2'b00, 10'd1, 10'd2, 64'h0, 64'h0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk("rr_grant", req_ready, exp_g[i]);
         chk("rr_rsp", rsp_valid, exp_r[i]);
         if (i > 0) chk("rr_data", rsp_rdata, exp_d[i]);
      end
      @(negedge clk);
      drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 64'h0, 64'h0);
      #1;
      chk("rr_rsp_last", rsp_valid, 2'b10);
      chk("rr_data_last", rsp_rdata, 64'h222);
      @(negedge clk);
      chk("rr_rsp_idle", rsp_valid, 2'b00);

      // lock held by req0 (lock=1,1, idle, 0) while req1 waits
      drive(2'b11, 2'b11, 2'b01, 10'd20, 10'd21, 64'h5, 64'h6);
      #1;
      chk("lk_take", req_ready, 2'b01);
      @(negedge clk);
      #1;
      chk("lk_hold", req_ready, 2'b01);
      @(negedge clk);
      drive(2'b10, 2'b11, 2'b00, 10'd20, 10'd21, 64'h5, 64'h6);
      #1;
      chk("lk_owner_idle", req_ready, 2'b00);
      chk("lk_idle_we", mem_write_en, 1'b0);
      @(negedge clk);
      drive(2'b11, 2'b11, 2'b00, 10'd20, 10'd21, 64'h5, 64'h6);
      #1;
      chk("lk_release", req_ready, 2'b01);
      @(negedge clk);
      #1;
      chk("lk_other_next", req_ready, 2'b10);

      // reset while req1 holds the lock with a read in flight
      @(negedge clk);
      drive(2'b10, 2'b00, 2'b10, 10'd0, 10'd2, 64'h0, 64'h0);
      #1;
      chk("rl_take", req_ready, 2'b10);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 64'h0, 64'h0);
      #1;
      chk("rl_rsp_drop", rsp_valid, 2'b00);
      @(negedge clk);
      chk("rl_rsp_hold", rsp_valid, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b11, 2'b00, 2'b00, 10'd1, 10'd2, 64'h0, 64'h0);
      #1;
      chk("rl_first", req_ready, 2'b01);
      chk("rl_rsp_none", rsp_valid, 2'b00);
      @(negedge clk);
      #1;
      chk("rl_second", req_ready, 2'b10);
      @(negedge clk);
      drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 64'h0, 64'h0);
      #1;
      chk("rl_rsp", rsp_valid, 2'b10);
      chk("rl_data", rsp_rdata, 64'h222);

`ifdef MEM_ARB_STATS_EN
      // 70000 conflict cycles saturate stat_conflict; grants split evenly
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b11, 2'b00, 2'b00, 10'd1, 10'd2, 64'h0, 64'h0);
      repeat (70000) @(negedge clk);
      drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 64'h0, 64'h0);
      #1;
      chk("st_conflict", stat_conflict, 16'hFFFF);
      chk("st_grant0", stat_grant0, 16'd35000);
      chk("st_grant1", stat_grant1, 16'd35000);
      drive(2'b11, 2'b00, 2'b00, 10'd1, 10'd2, 64'h0, 64'h0);
      repeat (3) @(negedge clk);
      drive(2'b00, 2'b00, 2'b00, 10'h0, 10'h0, 64'h0, 64'h0);
      #1;
      chk("st_conflict_sat", stat_conflict, 16'hFFFF);
      chk("st_grant_sum", 64'(stat_grant0) + 64'(stat_grant1), 64'd70003);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
